// File: rtl/mul_hash_sched.sv
// rtl/mul_hash_sched.sv - round-robin scheduler sharing one mul_hash pipeline, credit-based FWFT response FIFO
module mul_hash_sched #(
  parameter int NREQ  = 4,
  parameter int NBITS = 15,
  parameter int LAT   = 11,
  parameter int TAGW  = 8,
  parameter int DEPTH = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*64-1:0]     req_data,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  output logic [NREQ-1:0]        req_ready,
  output logic                   hash_ce,
  output logic [63:0]            hash_a,
  output logic                   hash_in_v,
  input  logic [NBITS-1:0]       hash_p,
  input  logic                   hash_out_v,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [TAGW-1:0]        rsp_tag,
  output logic [NBITS-1:0]       rsp_hash,
  output logic                   err_align
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(LAT + 1);
  localparam int EW = IDW + TAGW + NBITS;

  // credits: ops issued but not yet handed to the consumer (in flight + queued)
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [IDW-1:0]  ptr;
  logic [DW-1:0]   drain;

  logic [IDW-1:0]  gnt;
  logic            gnt_found;
  logic [63:0]     gnt_data;
  logic [TAGW-1:0] gnt_tag;
  logic            issue_ok;
  logic            issue;
  logic            push;
  logic            pop;

  // sideband registered alongside hash_a so stage 0 of the shift register lines up with hash_in_v
  logic [IDW-1:0]  in_id;
  logic [TAGW-1:0] in_tag;
  logic [LAT-1:0]  sb_v;
  logic [IDW-1:0]  sb_id  [LAT];
  logic [TAGW-1:0] sb_tag [LAT];

  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [EW-1:0]   head;

  // the hash pipeline is never stalled; backpressure is absorbed by the credit count
  assign hash_ce = 1'b1;

  // round-robin search: lowest offset from ptr wins, so scan offsets from high to low
  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req_valid[idx]) begin
        gnt       = IDW'(idx);
        gnt_found = 1'b1;
      end
    end
  end

  assign gnt_data = req_data[64*int'(gnt) +: 64];
  assign gnt_tag  = req_tag[TAGW*int'(gnt) +: TAGW];
  assign issue_ok = !rst && (drain == '0) && (cnt < CW'(DEPTH));
  assign issue    = issue_ok && gnt_found;

  // one-hot grant, only when a credit is available and the drain window has closed
  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt] = 1'b1;
  end

  assign push      = sb_v[LAT-1];
  assign head      = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_cnt != '0) && !rst && (drain == '0);
  assign pop       = rsp_valid && rsp_ready;
  assign {rsp_id, rsp_tag, rsp_hash} = head;

  // drain window after reset, round-robin pointer and credit accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      drain <= DW'(LAT);
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      if (drain != '0) drain <= drain - DW'(1);
      if (issue) ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
      if (issue && !pop)      cnt <= cnt + CW'(1);
      else if (!issue && pop) cnt <= cnt - CW'(1);
    end
  end

  // register the granted key and its sideband toward the hash pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      hash_in_v <= 1'b0;
      hash_a    <= '0;
      in_id     <= '0;
      in_tag    <= '0;
    end else begin
      hash_in_v <= issue;
      if (issue) begin
        hash_a <= gnt_data;
        in_id  <= gnt;
        in_tag <= gnt_tag;
      end
    end
  end

  // sideband valids track ops through the hash latency; cleared on reset to discard in-flight work
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
    end else begin
      sb_v[0] <= hash_in_v;
      for (int k = 1; k < LAT; k++) sb_v[k] <= sb_v[k-1];
    end
  end

  // sideband payload follows the valids; no reset needed since valids qualify it
  always_ff @(posedge clk) begin
    sb_id[0]  <= in_id;
    sb_tag[0] <= in_tag;
    for (int k = 1; k < LAT; k++) begin
      sb_id[k]  <= sb_id[k-1];
      sb_tag[k] <= sb_tag[k-1];
    end
  end

  // sticky flag when the hash result valid disagrees with our own bookkeeping
  always_ff @(posedge clk) begin
    if (rst) err_align <= 1'b0;
    else if ((drain == '0) && (hash_out_v != sb_v[LAT-1])) err_align <= 1'b1;
  end

  // response FIFO pointers and occupancy; push and pop may coincide at any level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  // FIFO storage; writes are driven by the sideband alone, never by hash_out_v
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {sb_id[LAT-1], sb_tag[LAT-1], hash_p};
  end

endmodule

// File: doc/mul_hash_sched.md
MUL_HASH_SCHED -- requirements
Module: mul_hash_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one mul_hash instance.
REQ-002 The block SHALL have parameter NBITS, default 15, hash result width (matches mul_hash NBITS).
REQ-003 The block SHALL have parameter LAT, default 11, mul_hash in_v-to-out_v latency in ce-enabled cycles.
REQ-004 The block SHALL have parameter TAGW, default 8, requester tag width.
REQ-005 The block SHALL have parameter DEPTH, default 16, response FIFO depth; DEPTH >= LAT+1.
REQ-006 The block SHALL have clk, in, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have rst, in, 1, a synchronous active-high reset.
REQ-008 The block SHALL have req_valid, in, NREQ, per-requester request valid.
REQ-009 The block SHALL have req_data, in, NREQ*64, per-requester 64-bit key; requester i occupies bits [64*i+63:64*i].
REQ-010 The block SHALL have req_tag, in, NREQ*TAGW, per-requester tag.
REQ-011 The block SHALL have req_ready, out, NREQ, one-hot-or-zero grant.
REQ-012 The block SHALL have hash_ce, out, 1, the mul_hash clock enable.
REQ-013 The block SHALL have hash_a, out, 64, the mul_hash key.
REQ-014 The block SHALL have hash_in_v, out, 1, the mul_hash input valid.
REQ-015 The block SHALL have hash_p, in, NBITS, the mul_hash result.
REQ-016 The block SHALL have hash_out_v, in, 1, the mul_hash result valid.
REQ-017 The block SHALL have rsp_valid, out, 1, response valid.
REQ-018 The block SHALL have rsp_ready, in, 1, response consumer ready.
REQ-019 The block SHALL have rsp_id, out, clog2(NREQ), the requester index of the response.
REQ-020 The block SHALL have rsp_tag, out, TAGW, the tag returned with the response.
REQ-021 The block SHALL have rsp_hash, out, NBITS, the hash value returned.
REQ-022 The block SHALL have err_align, out, 1, a sticky flag for hash_out_v / sideband mismatch.

Function
REQ-023 hash_ce SHALL be 1 in every cycle, including during reset; the pipeline is never stalled and backpressure is handled by credits.
REQ-024 A credit counter cnt (0..DEPTH) SHALL equal in-flight ops plus FIFO occupancy: +1 on issue, -1 on rsp handshake (rsp_valid&rsp_ready), unchanged when both occur in the same cycle.
REQ-025 Issue SHALL be allowed only when cnt < DEPTH, drain == 0 and not rst.
REQ-026 Arbitration SHALL be round-robin with pointer ptr: grant the first i with req_valid[i]=1, searching from ptr upward with wrap-around.
REQ-027 req_ready[g] SHALL be combinational, asserted only for the granted g when issue is allowed; handshake = req_valid[g]&req_ready[g].
REQ-028 On a handshake with g, ptr SHALL become (g+1) mod NREQ; with no handshake ptr SHALL hold.
REQ-029 hash_a and hash_in_v SHALL be registered: on a handshake in cycle t, hash_a=req_data[g] and hash_in_v=1 in cycle t+1; otherwise hash_in_v=0 and hash_a holds.
REQ-030 A LAT-deep sideband shift register SHALL carry {valid,id,tag} aligned with hash_in_v, so its tail aligns with hash_out_v/hash_p.
REQ-031 When the sideband tail is valid, {id,tag,hash_p} SHALL be written to the FIFO; overflow is impossible by REQ-024.
REQ-032 If hash_out_v != sideband tail valid while drain==0, err_align SHALL set and hold until rst; the FIFO write is governed by the sideband only.
REQ-033 The FIFO SHALL be first-word-fall-through: rsp_* present the head while non-empty, and rsp_valid=0 when empty.
REQ-034 A simultaneous FIFO write and read SHALL be legal at any occupancy, including full with pop and empty with push (push visible the next cycle).
REQ-035 The response order SHALL equal the issue order; the per-requester key->response latency when the FIFO is empty and rsp_ready=1 is LAT+2 cycles (handshake cycle t -> rsp_valid in cycle t+LAT+2).
REQ-036 Drain counter drain: rst loads LAT, and it decrements to 0 each cycle thereafter; while drain != 0, hash_out_v is ignored, because the mul_hash pipeline is not reset.

Reset
REQ-037 On rst=1 at a clock edge: cnt=0, ptr=0, FIFO empty, sideband valids=0, hash_in_v=0, hash_a=0, err_align=0, drain=LAT.
REQ-038 During rst and while drain != 0: req_ready=0 and rsp_valid=0; a reset mid-operation discards all in-flight and queued responses.

Verification
REQ-039 The bench SHALL check a single request: req 2, key 0x0000000000000001, tag 0x5A, rsp_ready=1 -> one response id=2, tag=0x5A, hash=model(key) at cycle t+13, with err_align=0.
REQ-040 The bench SHALL check fairness: all 4 requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 and responses in that order.
REQ-041 The bench SHALL check backpressure: rsp_ready=0 with continuous requests -> exactly 16 grants, then req_ready=0; one pop then permits exactly one more grant.
REQ-042 The bench SHALL check a full-FIFO simultaneous pop and write: occupancy stays 16, and no loss or duplicate occurs.
REQ-043 The bench SHALL check reset mid-flight: rst for 1 cycle with 5 ops in flight -> no responses, req_ready=0 for 11 cycles, then normal operation.
REQ-044 The bench SHALL check alignment: inject a spurious hash_out_v after the drain period -> err_align=1 and sticky, with no FIFO write.
